sram_loader: RTL and testbench

SRAM_LOADER -- requirements
Module: sram_loader

---
 rtl/hack_mem_pkg.sv | 25 ++
 rtl/sram_loader.sv | 205 ++++++++++++++++++++
 tb/tb_sram_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// ---------------------------------------------------------------------------
// hack_mem_pkg
// Shared definitions for the memory-side blocks of the hack platform.
//
// Contents:
//   loadState_t : state encoding for the SRAM loader (IDLE, LOAD, VERIFY, CHECK)
//   packWord    : joins two source bytes into one 16-bit word, big-endian order
// ---------------------------------------------------------------------------
package hack_mem_pkg;

   // Loader sequence: fill the SRAM, read it all back, compare checksums.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      CHECK  = 2'd3
   } loadState_t;

   // The first byte of a pair is the high byte of the word.
   function automatic logic [15:0] packWord(input logic [7:0] hiByte,
                                            input logic [7:0] loByte);
      return {hiByte, loByte};
   endfunction

endpackage

// File: rtl/sram_loader.sv
// ---------------------------------------------------------------------------
// sram_loader
// Streams bytes from a source into an SRAM as 16-bit words, then reads the
// whole range back and compares a modulo-2^16 checksum of what was written
// against a checksum of what was read.
//
// Parameters:
//   AW : word-address width of the SRAM request bus
//   DW : data width (only 16 is supported)
//
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, length        : one-cycle start pulse and word count (sampled on start)
//   byte_valid/data/ready: byte source handshake
//   read, write, address : SRAM controller request strobes and word address
//   wdata, wstrb, rdata  : write data, active-low byte enables, read data
//   busy, done, error    : load in progress, completion pulse, checksum mismatch
// ---------------------------------------------------------------------------
module sram_loader
   import hack_mem_pkg::*;
#(
   parameter int AW = 18,
   parameter int DW = 16
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [AW-1:0]   length,
   input  logic            byte_valid,
   input  logic [7:0]      byte_data,
   output logic            byte_ready,
   output logic            read,
   output logic            write,
   output logic [AW-1:0]   address,
   output logic [DW-1:0]   wdata,
   output logic [DW/8-1:0] wstrb,
   input  logic [DW-1:0]   rdata,
   output logic            busy,
   output logic            done,
   output logic            error
);

   loadState_t      r_state;
   logic            r_byteReady;
   logic            r_read;
   logic            r_write;
   logic [AW-1:0]   r_address;
   logic [DW-1:0]   r_wdata;
   logic            r_busy;
   logic            r_done;
   logic            r_error;

   // Byte assembler: holds the high byte until its partner arrives.
   logic [7:0]      r_hiByte;
   logic            r_haveHi;

   // Word counters; all wrap naturally at 2^AW.
   logic [AW-1:0]   r_wordIdx;
   logic [AW-1:0]   r_lastIdx;
   logic [AW-1:0]   r_rdIdx;
   logic [AW-1:0]   r_sampIdx;
   logic            r_rdActive;
   logic            r_rdPend;

   logic [15:0]     r_sumWrite;
   logic [15:0]     r_sumRead;

   logic            w_accept;
   logic [15:0]     w_word;

   assign w_accept = byte_valid && r_byteReady;
   assign w_word   = packWord(r_hiByte, byte_data);

   // Controller byte enables are active-low, so both lanes stay enabled.
   assign wstrb      = '0;
   assign byte_ready = r_byteReady;
   assign read       = r_read;
   assign write      = r_write;
   assign address    = r_address;
   assign wdata      = r_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

   // Whole loader sequence in one registered FSM. done and write are
   // single-cycle pulses, so they default low every cycle and are only
   // raised on the edge that produces them.
   // Read data arrives one cycle after its read strobe; r_rdPend is the
   // strobe delayed by one cycle and marks the cycle whose end samples rdata.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_byteReady <= 1'b0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_address   <= '0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_hiByte    <= '0;
         r_haveHi    <= 1'b0;
         r_wordIdx   <= '0;
         r_lastIdx   <= '0;
         r_rdIdx     <= '0;
         r_sampIdx   <= '0;
         r_rdActive  <= 1'b0;
         r_rdPend    <= 1'b0;
         r_sumWrite  <= '0;
         r_sumRead   <= '0;
      end else begin
         r_done  <= 1'b0;
         r_write <= 1'b0;

         unique case (r_state)
            IDLE: begin
               r_read   <= 1'b0;
               r_rdPend <= 1'b0;
               if (start) begin
                  r_error    <= 1'b0;
                  r_sumWrite <= '0;
                  r_sumRead  <= '0;
                  r_wordIdx  <= '0;
                  r_rdIdx    <= '0;
                  r_sampIdx  <= '0;
                  r_haveHi   <= 1'b0;
                  r_rdActive <= 1'b0;
                  r_lastIdx  <= length - AW'(1);
                  if (length == '0) begin
                     // Nothing to move: report a clean completion right away.
                     r_done <= 1'b1;
                  end else begin
                     r_state     <= LOAD;
                     r_byteReady <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
            end

            LOAD: begin
               if (w_accept) begin
                  if (!r_haveHi) begin
                     r_hiByte <= byte_data;
                     r_haveHi <= 1'b1;
                  end else begin
                     r_haveHi   <= 1'b0;
                     r_write    <= 1'b1;
                     r_address  <= r_wordIdx;
                     r_wdata    <= w_word;
                     r_sumWrite <= r_sumWrite + w_word;
                     r_wordIdx  <= r_wordIdx + AW'(1);
                     if (r_wordIdx == r_lastIdx) begin
                        // Stop taking bytes on the same edge as the final
                        // write so the source is never over-consumed. Reads
                        // are first issued on the next edge, after the
                        // final write strobe has dropped.
                        r_byteReady <= 1'b0;
                        r_rdActive  <= 1'b1;
                        r_rdIdx     <= '0;
                        r_state     <= VERIFY;
                     end
                  end
               end
            end

            VERIFY: begin
               r_rdPend <= r_read;
               if (r_rdActive) begin
                  r_read    <= 1'b1;
                  r_address <= r_rdIdx;
                  r_rdIdx   <= r_rdIdx + AW'(1);
                  if (r_rdIdx == r_lastIdx) begin
                     r_rdActive <= 1'b0;
                  end
               end else begin
                  r_read <= 1'b0;
               end
               if (r_rdPend) begin
                  r_sumRead <= r_sumRead + rdata[15:0];
                  r_sampIdx <= r_sampIdx + AW'(1);
                  if (r_sampIdx == r_lastIdx) begin
                     r_state <= CHECK;
                  end
               end
            end

            CHECK: begin
               // error stays put until the next accepted start clears it.
               r_error  <= (r_sumWrite != r_sumRead);
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_read   <= 1'b0;
               r_rdPend <= 1'b0;
               r_state  <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_loader.sv
// ---------------------------------------------------------------------------
// tb_sram_loader
// Self-checking bench for sram_loader. A one-cycle-latency SRAM model sits
// on the request bus; expected writes and reads are queued when a load is
// driven and popped as the loader issues them.
// ---------------------------------------------------------------------------
module tb_sram_loader;

   localparam int AW = 18;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start;
   logic [AW-1:0]   length;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic            read;
   logic            write;
   logic [AW-1:0]   address;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic            done;
   logic            error;

   int checkCount = 0;
   int errorCount = 0;

   // Scoreboard queues filled by the stimulus side.
   int unsigned expWrAddrQ[$];
   logic [15:0] expWrDataQ[$];
   int unsigned expRdAddrQ[$];
   logic [7:0]  byteQ[$];

   // Monitor bookkeeping.
   int  doneCount  = 0;
   int  writeCount = 0;
   int  readCount  = 0;
   int  xferCount  = 0;
   bit  byteParity = 1'b0;
   bit  pendingWrite = 1'b0;
   bit  errorAtDone  = 1'b0;

   // SRAM model; corrupt flips bit 0 of word 1 on readback.
   logic [15:0] mem [0:15];
   bit          corrupt = 1'b0;

   sram_loader #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .length     (length),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .read       (read),
      .write      (write),
      .address    (address),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .rdata      (rdata),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // SRAM controller with a read latency of one cycle.
   always @(posedge clk) begin
      if (write) mem[address[3:0]] <= wdata;
      if (read) rdata <= mem[address[3:0]] ^ ((corrupt && address == AW'(1)) ? 16'h0001 : 16'h0000);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Monitor: runs just after each falling edge so stimulus driven on that
   // edge is already visible.
   always @(negedge clk) begin
      #1;
      if (!reset_n) begin
         pendingWrite = 1'b0;
         byteParity   = 1'b0;
      end else begin
         if (write || pendingWrite) checkOutput("writeTiming", write, pendingWrite);
         if (read || write) checkOutput("readWriteOverlap", read && write, 0);
         if (write) begin
            writeCount++;
            checkOutput("writeExpected", expWrAddrQ.size() != 0, 1);
            if (expWrAddrQ.size() != 0) begin
               checkOutput("writeAddr", address, expWrAddrQ.pop_front());
               checkOutput("writeData", wdata, expWrDataQ.pop_front());
            end
         end
         if (read) begin
            readCount++;
            checkOutput("readExpected", expRdAddrQ.size() != 0, 1);
            if (expRdAddrQ.size() != 0) checkOutput("readAddr", address, expRdAddrQ.pop_front());
         end
         if (done) begin
            doneCount++;
            errorAtDone = error;
         end
         pendingWrite = 1'b0;
         if (byte_valid && byte_ready) begin
            xferCount++;
            byteParity = ~byteParity;
            if (!byteParity) pendingWrite = 1'b1;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic startLoad(input int len);
      start  = 1'b1;
      length = AW'(len);
      @(negedge clk);
      start  = 1'b0;
      length = AW'(7);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gapped);
      int cnt = 0;
      if (gapped) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 20) checkOutput("byteReadyTimeout", byte_ready, 1);
      @(negedge clk);
   endtask

   // Queue the expected traffic, start the load and feed byteQ. The source
   // keeps offering a byte afterwards so over-consumption would show up.
   task automatic applyStimulus(input int len, input bit gapped);
      writeCount = 0;
      readCount  = 0;
      xferCount  = 0;
      for (int i = 0; i < len; i++) begin
         expWrAddrQ.push_back(i);
         expWrDataQ.push_back({byteQ[2*i], byteQ[2*i+1]});
         expRdAddrQ.push_back(i);
      end
      startLoad(len);
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("errorClearedOnStart", error, 0);
      for (int i = 0; i < 2*len; i++) sendByte(byteQ[i], gapped);
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
   endtask

   task automatic waitDone(input bit expErr, input int len);
      int startDone = doneCount;
      int cnt = 0;
      while (doneCount == startDone && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("doneSeen", doneCount - startDone, 1);
      repeat (4) @(negedge clk);
      byte_valid = 1'b0;
      checkOutput("donePulseCount", doneCount - startDone, 1);
      checkOutput("errorAtDone", errorAtDone, expErr);
      checkOutput("errorHeld", error, expErr);
      checkOutput("busyAfterDone", busy, 0);
      checkOutput("byteReadyAfterDone", byte_ready, 0);
      checkOutput("bytesConsumed", xferCount, 2*len);
      checkOutput("writeCount", writeCount, len);
      checkOutput("readCount", readCount, len);
      checkOutput("writeQueueLeft", expWrAddrQ.size(), 0);
      checkOutput("readQueueLeft", expRdAddrQ.size(), 0);
   endtask

   task automatic loadBytes(input logic [7:0] b0, b1, b2, b3, b4, b5);
      byteQ = {b0, b1, b2, b3, b4, b5};
   endtask

   task automatic checkAllLow(input string tag);
      checkOutput({tag, ".read"}, read, 0);
      checkOutput({tag, ".write"}, write, 0);
      checkOutput({tag, ".byteReady"}, byte_ready, 0);
      checkOutput({tag, ".busy"}, busy, 0);
      checkOutput({tag, ".done"}, done, 0);
      checkOutput({tag, ".error"}, error, 0);
      checkOutput({tag, ".address"}, address, 0);
      checkOutput({tag, ".wdata"}, wdata, 0);
      checkOutput({tag, ".wstrb"}, wstrb, 0);
   endtask

   initial begin
      int startDone;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      reset_n    = 1'b0;
      start      = 1'b0;
      length     = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) @(negedge clk);
      checkAllLow("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] three-word load");
      loadBytes(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01);
      applyStimulus(3, 1'b0);
      waitDone(1'b0, 3);

      $display("[TB] zero-length load");
      writeCount = 0;
      readCount  = 0;
      startDone  = doneCount;
      startLoad(0);
      checkOutput("zeroLenDone", done, 1);
      checkOutput("zeroLenError", error, 0);
      repeat (5) @(negedge clk);
      checkOutput("zeroLenDonePulses", doneCount - startDone, 1);
      checkOutput("zeroLenWrites", writeCount, 0);
      checkOutput("zeroLenReads", readCount, 0);

      $display("[TB] corrupted readback");
      corrupt = 1'b1;
      loadBytes(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01);
      applyStimulus(3, 1'b0);
      waitDone(1'b1, 3);
      corrupt = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("errorStillHeld", error, 1);

      $display("[TB] gapped source");
      loadBytes(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01);
      applyStimulus(3, 1'b1);
      waitDone(1'b0, 3);

      $display("[TB] start while busy");
      byteQ = {8'h11, 8'h22, 8'h33, 8'h44};
      writeCount = 0;
      readCount  = 0;
      xferCount  = 0;
      expWrAddrQ.push_back(0); expWrDataQ.push_back(16'h1122); expRdAddrQ.push_back(0);
      expWrAddrQ.push_back(1); expWrDataQ.push_back(16'h3344); expRdAddrQ.push_back(1);
      startLoad(2);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      byte_valid = 1'b0;
      start  = 1'b1;
      length = AW'(5);
      @(negedge clk);
      start  = 1'b0;
      checkOutput("busyDuringExtraStart", busy, 1);
      sendByte(8'h33, 1'b0);
      sendByte(8'h44, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      waitDone(1'b0, 2);

      $display("[TB] reset in the middle of a load");
      writeCount = 0;
      expWrAddrQ.push_back(0); expWrDataQ.push_back(16'h5678);
      startLoad(3);
      sendByte(8'h56, 1'b0);
      sendByte(8'h78, 1'b0);
      sendByte(8'h9A, 1'b0);
      reset_n    = 1'b0;
      byte_valid = 1'b0;
      #1;
      checkAllLow("midLoadReset");
      checkOutput("writesBeforeReset", writeCount, 1);
      expWrAddrQ.delete();
      expWrDataQ.delete();
      expRdAddrQ.delete();
      repeat (2) @(negedge clk);
      checkOutput("writesDuringReset", writeCount, 1);
      reset_n = 1'b1;
      @(negedge clk);
      byteQ = {8'hBE, 8'hEF};
      applyStimulus(1, 1'b0);
      waitDone(1'b0, 1);
      checkOutput("memWord0", mem[0], 16'hBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
